// File: rtl/qam16_demapper.sv
`default_nettype none
// ============================================================================
//  Module   : qam16_demapper
//  Purpose  : Hard-decision 16-QAM demapper. Slices each signed I/Q sample
//             pair into a 4-bit Gray symbol and packs two symbols per byte
//             (first symbol in the high nibble). A burst with an odd symbol
//             count ends in a zero-padded byte flagged by out_pad.
//  Ports    : clk, rst_n          - clock, asynchronous active-low reset
//             in_valid/in_ready   - input sample-pair handshake
//             in_re, in_im        - signed I/Q samples (SAMPLE_WIDTH bits)
//             in_last             - final symbol of a burst
//             out_valid/out_ready - output byte handshake
//             out_data            - packed byte {first[3:0], second[3:0]}
//             out_last            - byte carries the burst's final symbol
//             out_pad             - low nibble is padding
//             sym_cnt             - wrapping count of accepted symbols
//  Revision : 1.0 - initial release
// ============================================================================
module qam16_demapper #(
  parameter int SAMPLE_WIDTH = 5,
  parameter int THRESH       = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SAMPLE_WIDTH-1:0] in_re,
  input  logic [SAMPLE_WIDTH-1:0] in_im,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              out_data,
  output logic                    out_last,
  output logic                    out_pad,
  output logic [CNT_WIDTH-1:0]    sym_cnt
);

  localparam logic signed [SAMPLE_WIDTH-1:0] c_thresh     = SAMPLE_WIDTH'(THRESH);
  localparam logic signed [SAMPLE_WIDTH-1:0] c_neg_thresh = -c_thresh;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_HALF  = 1'b1
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [3:0]           r_hold, w_hold_nxt;
  logic [7:0]           r_out_data, w_out_data_nxt;
  logic                 r_out_last, w_out_last_nxt;
  logic                 r_out_pad, w_out_pad_nxt;
  logic                 r_out_valid, w_out_valid_nxt;
  logic [CNT_WIDTH-1:0] r_sym_cnt;
  logic                 w_accept;
  logic [3:0]           w_nibble;

  // Per-axis decision; zero falls on the positive side, so the sign bit
  // alone separates the two inner regions.
  function automatic logic [1:0] f_slice(input logic signed [SAMPLE_WIDTH-1:0] x);
    if (x < c_neg_thresh)
      f_slice = 2'b00;
    else if (x[SAMPLE_WIDTH-1])
      f_slice = 2'b01;
    else if (x < c_thresh)
      f_slice = 2'b11;
    else
      f_slice = 2'b10;
  endfunction

  assign w_nibble = {f_slice(in_re), f_slice(in_im)};

  // Input side may advance whenever the output register is free or is
  // being drained this cycle.
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_hold_nxt      = r_hold;
    w_out_data_nxt  = r_out_data;
    w_out_last_nxt  = r_out_last;
    w_out_pad_nxt   = r_out_pad;
    w_out_valid_nxt = r_out_valid && !out_ready;

    if (w_accept) begin
      case (r_state)
        ST_EMPTY: begin
          if (in_last) begin
            w_out_data_nxt  = {w_nibble, 4'b0000};
            w_out_last_nxt  = 1'b1;
            w_out_pad_nxt   = 1'b1;
            w_out_valid_nxt = 1'b1;
          end else begin
            w_hold_nxt  = w_nibble;
            w_state_nxt = ST_HALF;
          end
        end
        ST_HALF: begin
          w_out_data_nxt  = {r_hold, w_nibble};
          w_out_last_nxt  = in_last;
          w_out_pad_nxt   = 1'b0;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = ST_EMPTY;
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_hold      <= 4'b0000;
      r_out_data  <= 8'h00;
      r_out_last  <= 1'b0;
      r_out_pad   <= 1'b0;
      r_out_valid <= 1'b0;
      r_sym_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold      <= w_hold_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_last  <= w_out_last_nxt;
      r_out_pad   <= w_out_pad_nxt;
      r_out_valid <= w_out_valid_nxt;
      if (w_accept)
        r_sym_cnt <= r_sym_cnt + CNT_WIDTH'(1);
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_pad   = r_out_pad;
  assign sym_cnt   = r_sym_cnt;

endmodule
`default_nettype wire

// File: tb/tb_qam16_demapper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_qam16_demapper
//  Purpose  : Self-checking bench for qam16_demapper. Bytes leaving the DUT
//             are collected and compared against a packing model built from
//             the decision rules; flow-control and counter behaviour are
//             checked inline per scenario.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_qam16_demapper;

  localparam int SW = 5;
  localparam int TH = 2;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] in_re;
  logic [SW-1:0] in_im;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic          out_last;
  logic          out_pad;
  logic [CW-1:0] sym_cnt;

  qam16_demapper #(
    .SAMPLE_WIDTH(SW),
    .THRESH      (TH),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_re    (in_re),
    .in_im    (in_im),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .out_pad  (out_pad),
    .sym_cnt  (sym_cnt)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         n_acc  = 0;
  bit         rand_bp = 1'b0;
  logic [9:0] rx_q[$];   // {last, pad, data}
  logic [9:0] exp_q[$];
  logic [3:0] pend[$];

  // Transfers happen at the next rising edge; inputs only change just after
  // rising edges, so the falling-edge view matches the transfer condition.
  always @(negedge clk)
    if (rst_n && out_valid && out_ready)
      rx_q.push_back({out_last, out_pad, out_data});

  // ---------------- reference model ----------------
  function automatic int ref_slice(int x);
    if (x < -TH)     return 0;
    else if (x < 0)  return 1;
    else if (x < TH) return 3;
    else             return 2;
  endfunction

  function automatic logic [3:0] ref_nib(int re, int im);
    return 4'(ref_slice(re) * 4 + ref_slice(im));
  endfunction

  // Mapper constellation level for a 2-bit Gray code.
  function automatic int lvl(int b);
    case (b)
      0:       return -3;
      1:       return -1;
      3:       return 1;
      default: return 3;
    endcase
  endfunction

  // Collect a burst's nibbles; at its end emit pairs, padding an odd tail.
  task automatic model_push(input logic [3:0] nib, input bit last);
    pend.push_back(nib);
    if (last) begin
      int n = pend.size();
      for (int i = 0; i < n; i += 2) begin
        logic [7:0] b;
        bit pad;
        pad = (i + 1 >= n);
        if (pad) b = {pend[i], 4'h0};
        else     b = {pend[i], pend[i+1]};
        exp_q.push_back({(i + 2 >= n), pad, b});
      end
      pend.delete();
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic send(input int re, input int im, input bit last);
    int w = 0;
    in_valid = 1'b1;
    in_re    = SW'(re);
    in_im    = SW'(im);
    in_last  = last;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        n_acc++;
        model_push(ref_nib(re, im), last);
        if (rand_bp) out_ready = 1'($urandom_range(0, 1));
        break;
      end
      @(posedge clk); #1;
      if (rand_bp) out_ready = 1'($urandom_range(0, 1));
      w++;
      if (w > 200) begin
        errors++; checks++;
        $display("FAIL send_timeout: in_ready stayed %b, required 1 within 200 cycles", in_ready);
        break;
      end
    end
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    rx_q.delete();
    exp_q.delete();
    pend.delete();
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_re     = '0;
    in_im     = '0;
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    clear_model();
    n_acc = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    checks++; if (out_pad !== 1'b0) begin errors++; $display("FAIL reset_out_pad: got %b want 0", out_pad); end
    checks++; if (sym_cnt !== '0) begin errors++; $display("FAIL reset_sym_cnt: got %0d want 0", sym_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_threshold_sweep();
    clear_model();
    for (int v = -16; v <= 15; v++) send(v, v, 1'b1);
    drain();
    checks++;
    if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL sweep_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL sweep_byte[%0d]: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    checks++;
    if (sym_cnt !== CW'(n_acc)) begin errors++; $display("FAIL sweep_sym_cnt: got %0d want %0d", sym_cnt, n_acc); end
  endtask

  task automatic test_loopback();
    do_reset();
    for (int n = 0; n < 16; n++) send(lvl(n / 4), lvl(n % 4), n == 15);
    drain();
    checks++;
    if (rx_q.size() !== 8) begin errors++; $display("FAIL loop_count: got %0d want 8", rx_q.size()); end
    for (int k = 0; k < rx_q.size() && k < 8; k++) begin
      logic [9:0] want;
      want = {(k == 7), 1'b0, 4'(2 * k), 4'(2 * k + 1)};
      checks++;
      if (rx_q[k] !== want) begin errors++; $display("FAIL loop_byte[%0d]: got %h want %h", k, rx_q[k], want); end
    end
    checks++;
    if (sym_cnt !== CW'(16)) begin errors++; $display("FAIL loop_sym_cnt: got %0d want 16", sym_cnt); end
  endtask

  task automatic test_odd_burst();
    clear_model();
    send(-3, -3, 1'b0);
    send( 1,  3, 1'b0);
    send( 3, -1, 1'b1);
    drain();
    checks++;
    if (rx_q.size() !== 2) begin errors++; $display("FAIL odd_count: got %0d want 2", rx_q.size()); end
    else begin
      checks++; if (rx_q[0] !== 10'h00E) begin errors++; $display("FAIL odd_byte0: got %h want 00e", rx_q[0]); end
      checks++; if (rx_q[1] !== 10'h390) begin errors++; $display("FAIL odd_byte1: got %h want 390", rx_q[1]); end
    end
  endtask

  task automatic test_backpressure();
    int ra, ia, rb, ib, rc, ic, rd, id;
    logic [7:0] held;
    clear_model();
    ra = $urandom_range(0, 31) - 16; ia = $urandom_range(0, 31) - 16;
    rb = $urandom_range(0, 31) - 16; ib = $urandom_range(0, 31) - 16;
    rc = $urandom_range(0, 31) - 16; ic = $urandom_range(0, 31) - 16;
    rd = $urandom_range(0, 31) - 16; id = $urandom_range(0, 31) - 16;
    held = {ref_nib(ra, ia), ref_nib(rb, ib)};
    out_ready = 1'b0;
    send(ra, ia, 1'b0);
    send(rb, ib, 1'b0);
    in_valid = 1'b1;
    in_re    = SW'(rc);
    in_im    = SW'(ic);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %b want 1", c, out_valid); end
      checks++; if (out_data !== held) begin errors++; $display("FAIL bp_out_data[%0d]: got %h want %h", c, out_data, held); end
      @(posedge clk); #1;
      in_im = SW'($urandom_range(0, 31));  // stalled data may wander
    end
    out_ready = 1'b1;
    send(rc, ic, 1'b0);
    send(rd, id, 1'b1);
    drain();
    checks++;
    if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL bp_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_byte[%0d]: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    checks++;
    if (sym_cnt !== CW'(n_acc)) begin errors++; $display("FAIL bp_sym_cnt: got %0d want %0d", sym_cnt, n_acc); end
  endtask

  task automatic test_reset_mid();
    int r1, i1, r2, i2;
    logic [9:0] want;
    out_ready = 1'b1;
    send(3, 3, 1'b0);
    send(-3, 1, 1'b0);
    send(1, -3, 1'b0);      // leaves a high nibble held
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (sym_cnt !== CW'(n_acc)) begin errors++; $display("FAIL mid_pre_sym_cnt: got %0d want %0d", sym_cnt, n_acc); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
    checks++; if (sym_cnt !== '0) begin errors++; $display("FAIL mid_sym_cnt: got %0d want 0", sym_cnt); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL mid_out_data: got %h want 00", out_data); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    clear_model();
    n_acc = 0;
    r1 = $urandom_range(0, 31) - 16; i1 = $urandom_range(0, 31) - 16;
    r2 = $urandom_range(0, 31) - 16; i2 = $urandom_range(0, 31) - 16;
    want = {2'b10, ref_nib(r1, i1), ref_nib(r2, i2)};
    send(r1, i1, 1'b0);
    send(r2, i2, 1'b1);
    drain();
    checks++;
    if (rx_q.size() !== 1) begin errors++; $display("FAIL mid_count: got %0d want 1", rx_q.size()); end
    else begin
      checks++;
      if (rx_q[0] !== want) begin errors++; $display("FAIL mid_byte: got %h want %h", rx_q[0], want); end
    end
  endtask

  task automatic test_random();
    clear_model();
    rand_bp = 1'b1;
    for (int b = 0; b < 25; b++) begin
      int len = $urandom_range(1, 5);
      for (int s = 0; s < len; s++)
        send($urandom_range(0, 31) - 16, $urandom_range(0, 31) - 16, s == len - 1);
    end
    rand_bp = 1'b0;
    drain();
    checks++;
    if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_byte[%0d]: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    checks++;
    if (sym_cnt !== CW'(n_acc)) begin errors++; $display("FAIL rand_sym_cnt: got %0d want %0d", sym_cnt, n_acc); end
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_last   = 1'b0;
    repeat (65535) @(posedge clk);
    #1;
    checks++;
    if (sym_cnt !== {CW{1'b1}}) begin errors++; $display("FAIL wrap_all_ones: got %0d want 65535", sym_cnt); end
    @(posedge clk); #1;
    checks++;
    if (sym_cnt !== '0) begin errors++; $display("FAIL wrap_zero: got %0d want 0", sym_cnt); end
    drain();
    clear_model();
  endtask

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_re     = '0;
    in_im     = '0;
    out_ready = 1'b1;
    test_reset();
    test_threshold_sweep();
    test_loopback();
    test_odd_burst();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
